// File: rtl/wrloader.sv
// Byte-stream write sequencer: parses SETADDR/WRITE (and optional FILL) commands into writes.
// Define WRLOADER_FILL_EN to build the FILL command (states FCNT, FDATA, FILL_RUN and rem).
module wrloader (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [16:0] m_wraddr,
  output logic [8:0]  m_wrdata,
  output logic        m_wrvalid,
  input  logic        m_wrready,
  output logic        err,
  output logic        busy
);

  typedef enum logic [2:0] {
    StIdle,
    StAddrHi,
    StAddrLo,
    StData
`ifdef WRLOADER_FILL_EN
    ,
    StFcnt,
    StFdata,
    StFillRun
`endif
  } state_e;

  state_e      state;
  logic [16:0] addr;
  logic        cmd_bit;   // bit 0 of the command: addr[16] or d[8]
  logic [7:0]  hi_byte;
`ifdef WRLOADER_FILL_EN
  logic [7:0]  rem;
`endif

  logic accept;
  logic hs;

`ifdef WRLOADER_FILL_EN
  assign in_ready = (state != StFillRun) && (!m_wrvalid || m_wrready);
`else
  assign in_ready = !m_wrvalid || m_wrready;
`endif
  assign accept = in_valid && in_ready;
  assign hs     = m_wrvalid && m_wrready;
  assign busy   = (state != StIdle) || m_wrvalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      addr      <= '0;
      cmd_bit   <= 1'b0;
      hi_byte   <= '0;
      m_wraddr  <= '0;
      m_wrdata  <= '0;
      m_wrvalid <= 1'b0;
      err       <= 1'b0;
`ifdef WRLOADER_FILL_EN
      rem       <= '0;
`endif
    end else begin
      // A load below in the same cycle overrides this clear.
      if (hs) m_wrvalid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (accept) begin
            cmd_bit <= in_data[0];
            unique casez (in_data)
              8'b1010_000?: state <= StAddrHi;
              8'b1100_000?: state <= StData;
`ifdef WRLOADER_FILL_EN
              8'b1110_000?: state <= StFcnt;
`endif
              default:      err   <= 1'b1;
            endcase
          end
        end
        StAddrHi: begin
          if (accept) begin
            hi_byte <= in_data;
            state   <= StAddrLo;
          end
        end
        StAddrLo: begin
          if (accept) begin
            addr  <= {cmd_bit, hi_byte, in_data};
            state <= StIdle;
          end
        end
        StData: begin
          if (accept) begin
            m_wraddr  <= addr;
            m_wrdata  <= {cmd_bit, in_data};
            m_wrvalid <= 1'b1;
            addr      <= addr + 17'd1;
            state     <= StIdle;
          end
        end
`ifdef WRLOADER_FILL_EN
        StFcnt: begin
          if (accept) begin
            rem   <= in_data;
            state <= StFdata;
          end
        end
        StFdata: begin
          if (accept) begin
            m_wraddr  <= addr;
            m_wrdata  <= {cmd_bit, in_data};
            m_wrvalid <= 1'b1;
            addr      <= addr + 17'd1;
            state     <= StFillRun;
          end
        end
        StFillRun: begin
          // m_wrdata already holds the fill value; only address and count advance.
          if (hs) begin
            if (rem != 8'd0) begin
              m_wraddr  <= addr;
              m_wrvalid <= 1'b1;
              addr      <= addr + 17'd1;
              rem       <= rem - 8'd1;
            end else begin
              state <= StIdle;
            end
          end
        end
`endif
        default: state <= StIdle;
      endcase
    end
  end

endmodule
